// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: shadows seg_in once per frame and drives one digit per slot.
// Optional per-frame brightness PWM under `SEG_SCAN_MUX_BRIGHTNESS_EN.

module seg_scan_lane #(
  parameter int LANE  = 0,
  parameter int IDX_W = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_capture,
  input  logic [6:0]       i_seg,
  input  logic [IDX_W-1:0] i_digit_idx,
  input  logic             i_lit,
  output logic [6:0]       o_seg_term,
  output logic             o_en_n
);
  localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(LANE);

  logic [6:0] r_shadow;
  logic       w_sel;

  always_ff @(posedge i_clk) begin
    if (i_reset)        r_shadow <= 7'h7F;
    else if (i_capture) r_shadow <= i_seg;
  end

  // Unselected lanes contribute all-ones so the top can AND-reduce active-low terms.
  assign w_sel      = i_lit && (i_digit_idx == MY_IDX);
  assign o_en_n     = ~w_sel;
  assign o_seg_term = w_sel ? r_shadow : 7'h7F;
endmodule

module seg_scan_mux #(
  parameter int NUM_DISPLAYS = 2,
  parameter int REFRESH_BITS = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
`ifdef SEG_SCAN_MUX_BRIGHTNESS_EN
  input  logic [3:0]                   i_brightness,
`endif
  input  logic [NUM_DISPLAYS-1:0][6:0] i_seg_in,
  output logic [6:0]                   o_seg_out,
  output logic [NUM_DISPLAYS-1:0]      o_digit_en,
  output logic                         o_frame_done
);
  localparam int IDX_W = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_DISPLAYS - 1);
  localparam logic [REFRESH_BITS-1:0] BLANK_TH = REFRESH_BITS'(BLANK_CYCLES);

  logic [REFRESH_BITS-1:0]       r_slot_cnt;
  logic [IDX_W-1:0]              r_digit_idx;
  logic                          r_frame_done;
  logic                          w_slot_end;
  logic                          w_capture;
  logic                          w_pwm_on;
  logic                          w_lit;
  logic [NUM_DISPLAYS-1:0][6:0]  w_seg_term;

  assign w_slot_end = &r_slot_cnt;
  assign w_capture  = w_slot_end && (r_digit_idx == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slot_cnt   <= '0;
      r_digit_idx  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_slot_cnt   <= r_slot_cnt + 1'b1;
      r_frame_done <= w_capture;
      if (w_slot_end)
        r_digit_idx <= (r_digit_idx == LAST_IDX) ? '0 : r_digit_idx + 1'b1;
    end
  end

`ifdef SEG_SCAN_MUX_BRIGHTNESS_EN
  logic [3:0] r_bright;

  always_ff @(posedge i_clk) begin
    if (i_reset)        r_bright <= 4'hF;
    else if (w_capture) r_bright <= i_brightness;
  end

  // PWM duty: the top nibble of the slot counter sweeps 0..15 across each slot.
  assign w_pwm_on = (r_slot_cnt[REFRESH_BITS-1 -: 4] <= r_bright);
`else
  assign w_pwm_on = 1'b1;
`endif

  assign w_lit = (r_slot_cnt >= BLANK_TH) && w_pwm_on;

  for (genvar g = 0; g < NUM_DISPLAYS; g++) begin : g_lane
    seg_scan_lane #(
      .LANE  (g),
      .IDX_W (IDX_W)
    ) u_lane (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_capture   (w_capture),
      .i_seg       (i_seg_in[g]),
      .i_digit_idx (r_digit_idx),
      .i_lit       (w_lit),
      .o_seg_term  (w_seg_term[g]),
      .o_en_n      (o_digit_en[g])
    );
  end

  always_comb begin
    o_seg_out = 7'h7F;
    for (int i = 0; i < NUM_DISPLAYS; i++)
      o_seg_out = o_seg_out & w_seg_term[i];
  end

  assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (2 digits, 16-cycle slots, 2 blank cycles).
// Expected outputs are queued per (reset epoch, cycle); a monitor pops and compares each cycle.

module tb_seg_scan_mux;
  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic [1:0][6:0] i_seg_in = '0;
  logic [6:0]      o_seg_out;
  logic [1:0]      o_digit_en;
  logic            o_frame_done;
`ifdef SEG_SCAN_MUX_BRIGHTNESS_EN
  logic [3:0]      i_brightness = 4'hF;
`endif

  seg_scan_mux #(
    .NUM_DISPLAYS (2),
    .REFRESH_BITS (4),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
`ifdef SEG_SCAN_MUX_BRIGHTNESS_EN
    .i_brightness (i_brightness),
`endif
    .i_seg_in     (i_seg_in),
    .o_seg_out    (o_seg_out),
    .o_digit_en   (o_digit_en),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         epoch;
    int         cyc;
    logic [6:0] seg;
    logic [1:0] en;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   epoch  = 0;
  int   cyc    = 0;
  logic prev_rst = 1'b0;

  task automatic expect_at(input int e, input int c, input logic [6:0] s,
                           input logic [1:0] en, input logic fd);
    exp_t x;
    x.epoch = e; x.cyc = c; x.seg = s; x.en = en; x.fd = fd;
    sbq.push_back(x);
  endtask

  // Monitor: cycle n is the cycle after n non-reset edges since the last reset edge.
  always @(posedge i_clk) begin
    logic rs;
    exp_t h;
    rs = i_reset;
    #1;
    if (rs) begin
      if (!prev_rst) epoch++;
      cyc = 0;
    end else begin
      cyc++;
    end
    prev_rst = rs;
    while (sbq.size() > 0 &&
           (sbq[0].epoch < epoch || (sbq[0].epoch == epoch && sbq[0].cyc < cyc))) begin
      h = sbq.pop_front();
      checks++; errors++;
      $display("FAIL missed e%0d c%0d: cycle never observed, now e%0d c%0d",
               h.epoch, h.cyc, epoch, cyc);
    end
    if (sbq.size() > 0 && sbq[0].epoch == epoch && sbq[0].cyc == cyc) begin
      h = sbq.pop_front();
      checks++;
      if (o_seg_out !== h.seg || o_digit_en !== h.en || o_frame_done !== h.fd) begin
        errors++;
        $display("FAIL out e%0d c%0d: got seg=%h en=%b fd=%b, want seg=%h en=%b fd=%b",
                 epoch, cyc, o_seg_out, o_digit_en, o_frame_done, h.seg, h.en, h.fd);
      end
    end
  end

  task automatic wait_cyc(input int n);
    int k;
    k = 0;
    while (cyc != n && k < 500) begin
      @(negedge i_clk);
      k++;
    end
    if (cyc != n) begin
      checks++; errors++;
      $display("FAIL wait_cyc: got cycle %0d, want %0d", cyc, n);
    end
  endtask

  initial begin
    // Epoch 1: power-on reset, seg_in {79,40}, update at 40 and 70
    expect_at(1,  0, 7'h7F, 2'b11, 1'b0);
    expect_at(1,  1, 7'h7F, 2'b11, 1'b0);
    expect_at(1,  2, 7'h7F, 2'b10, 1'b0);
    expect_at(1, 15, 7'h7F, 2'b10, 1'b0);
    expect_at(1, 16, 7'h7F, 2'b11, 1'b0);
    expect_at(1, 18, 7'h7F, 2'b01, 1'b0);
    expect_at(1, 31, 7'h7F, 2'b01, 1'b0);
    expect_at(1, 32, 7'h7F, 2'b11, 1'b1);
    expect_at(1, 33, 7'h7F, 2'b11, 1'b0);
    expect_at(1, 34, 7'h40, 2'b10, 1'b0);
    expect_at(1, 47, 7'h40, 2'b10, 1'b0);
    expect_at(1, 48, 7'h7F, 2'b11, 1'b0);
    expect_at(1, 50, 7'h79, 2'b01, 1'b0);
    expect_at(1, 63, 7'h79, 2'b01, 1'b0);
    expect_at(1, 64, 7'h7F, 2'b11, 1'b1);
    expect_at(1, 66, 7'h30, 2'b10, 1'b0);
    expect_at(1, 82, 7'h24, 2'b01, 1'b0);
    expect_at(1, 96, 7'h7F, 2'b11, 1'b1);
    expect_at(1, 98, 7'h5B, 2'b10, 1'b0);
    i_seg_in = {7'h79, 7'h40};
    i_reset  = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    wait_cyc(40); i_seg_in = {7'h24, 7'h30};
    wait_cyc(70); i_seg_in = {7'h06, 7'h5B};
    wait_cyc(99);

    // Epochs 2-4: mid-frame reset, then reset coincident with a capture edge
    expect_at(2, 34, 7'h40, 2'b10, 1'b0);
    expect_at(2, 45, 7'h40, 2'b10, 1'b0);
    expect_at(3,  0, 7'h7F, 2'b11, 1'b0);
    expect_at(3,  2, 7'h7F, 2'b10, 1'b0);
    expect_at(3, 31, 7'h7F, 2'b01, 1'b0);
    expect_at(4,  0, 7'h7F, 2'b11, 1'b0);
    expect_at(4,  1, 7'h7F, 2'b11, 1'b0);
    expect_at(4,  2, 7'h7F, 2'b10, 1'b0);
    expect_at(4, 18, 7'h7F, 2'b01, 1'b0);
    expect_at(4, 32, 7'h7F, 2'b11, 1'b1);
    expect_at(4, 34, 7'h40, 2'b10, 1'b0);
    i_seg_in = {7'h79, 7'h40};
    i_reset  = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    wait_cyc(45); i_reset = 1'b1;
    @(negedge i_clk); i_reset = 1'b0;
    wait_cyc(31); i_reset = 1'b1;
    @(negedge i_clk); i_reset = 1'b0;
    wait_cyc(35);

`ifdef SEG_SCAN_MUX_BRIGHTNESS_EN
    // Epoch 5: brightness 7 for frame 2, then 0 for frame 3
    expect_at(5,  5, 7'h7F, 2'b10, 1'b0);
    expect_at(5, 12, 7'h7F, 2'b10, 1'b0);
    expect_at(5, 32, 7'h7F, 2'b11, 1'b1);
    expect_at(5, 34, 7'h40, 2'b10, 1'b0);
    expect_at(5, 39, 7'h40, 2'b10, 1'b0);
    expect_at(5, 40, 7'h7F, 2'b11, 1'b0);
    expect_at(5, 47, 7'h7F, 2'b11, 1'b0);
    expect_at(5, 50, 7'h79, 2'b01, 1'b0);
    expect_at(5, 55, 7'h79, 2'b01, 1'b0);
    expect_at(5, 56, 7'h7F, 2'b11, 1'b0);
    expect_at(5, 64, 7'h7F, 2'b11, 1'b1);
    expect_at(5, 66, 7'h7F, 2'b11, 1'b0);
    expect_at(5, 70, 7'h7F, 2'b11, 1'b0);
    expect_at(5, 82, 7'h7F, 2'b11, 1'b0);
    expect_at(5, 96, 7'h7F, 2'b11, 1'b1);
    i_brightness = 4'd7;
    i_reset      = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    wait_cyc(50); i_brightness = 4'd0;
    wait_cyc(97);
`endif

    begin
      int k;
      k = 0;
      while (sbq.size() > 0 && k < 300) begin
        @(negedge i_clk);
        k++;
      end
    end
    while (sbq.size() > 0) begin
      exp_t h;
      h = sbq.pop_front();
      checks++; errors++;
      $display("FAIL leftover e%0d c%0d: expectation never reached", h.epoch, h.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter NUM_DISPLAYS, default 2: number of seven-segment digits scanned; SHALL be >= 1.
REQ-002 Parameter REFRESH_BITS, default 16: width of the per-digit slot counter, so one slot is 2^REFRESH_BITS clocks; SHALL be >= 4.
REQ-003 Parameter BLANK_CYCLES, default 4: anti-ghosting dead time at the start of each slot; SHALL be < 2^REFRESH_BITS.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 seg_in  input  [NUM_DISPLAYS-1:0][6:0]  active-low segment patterns, digit 0 at index 0, as produced by the upstream counter/decoder stage.
REQ-007 seg_out  output  7  active-low segment drive shared by all digits.
REQ-008 digit_en  output  NUM_DISPLAYS  active-low one-cold digit select.
REQ-009 frame_done  output  1  one-cycle pulse marking the first cycle of a new scan frame.

Function
REQ-010 slot_cnt (REFRESH_BITS wide) SHALL increment every cycle and wrap from all-ones to 0.
REQ-011 digit_idx SHALL advance on the slot_cnt wrap, from NUM_DISPLAYS-1 back to 0; with NUM_DISPLAYS=1 it stays 0.
REQ-012 A shadow register SHALL capture all of seg_in on the edge where digit_idx=NUM_DISPLAYS-1 and slot_cnt is all-ones; seg_in changes between captures SHALL NOT affect the outputs.
REQ-013 frame_done SHALL be high exactly in the cycle following each shadow capture (digit_idx=0, slot_cnt=0), and low otherwise.
REQ-014 While slot_cnt < BLANK_CYCLES: digit_en = all ones and seg_out = 7'h7F.
REQ-015 While slot_cnt >= BLANK_CYCLES (and lit per REQ-021): digit_en bit digit_idx = 0 with all other bits 1, and seg_out = shadow[digit_idx].
REQ-016 Outputs SHALL be decoded from registered state in the same cycle; there is no extra pipeline latency.
REQ-017 Exactly one digit_en bit SHALL be low at any time, or none.

Reset
REQ-018 While reset is high at a clock edge, the following SHALL be cleared on that edge: slot_cnt=0, digit_idx=0, shadow=all ones (blank), frame_done=0.
REQ-019 Because slot_cnt=0 < BLANK_CYCLES after reset, seg_out=7'h7F and digit_en=all ones in the first cycle after reset.
REQ-020 Reset asserted mid-slot or mid-frame SHALL take priority over every other update, including a coincident shadow capture.

Configuration
REQ-021 Macro SEG_SCAN_MUX_BRIGHTNESS_EN defined: adds input brightness [3:0]. brightness is captured into the shadow with seg_in. A slot is lit only while slot_cnt >= BLANK_CYCLES and slot_cnt[REFRESH_BITS-1 -: 4] <= shadow brightness; outside that window the REQ-014 blank values apply. Reset value of the shadow brightness is 4'hF.
REQ-022 Macro SEG_SCAN_MUX_BRIGHTNESS_EN undefined: there is no brightness port, and behaviour is identical to brightness=4'hF.

Verification (NUM_DISPLAYS=2, REFRESH_BITS=4, BLANK_CYCLES=2; slot=16, frame=32 cycles; cycle n is counted from the first cycle after reset release)
REQ-023 Reset for 3 cycles -> seg_out=7'h7F, digit_en=2'b11, frame_done=0. Cycles 2-15: digit_en=2'b10, seg_out=7'h7F (blank shadow).
REQ-024 seg_in={7'h79,7'h40} held from reset release:
- cycle 32: frame_done=1.
- cycles 32-33: blank.
- cycles 34-47: digit_en=2'b10, seg_out=7'h40.
- cycles 48-49: blank.
- cycles 50-63: digit_en=2'b01, seg_out=7'h79.
REQ-025 seg_in changed to {7'h24,7'h30} at cycle 40 -> outputs keep 7'h40/7'h79 until cycle 63; from cycle 66, seg_out=7'h30.
REQ-026 reset pulsed at cycle 45 -> next cycle seg_out=7'h7F, digit_en=2'b11, frame_done=0, shadow blank; the timing of REQ-023 restarts.
REQ-027 With the macro and brightness=4'd7 -> digit lit only in slot cycles 2-7. With brightness=4'd0 -> digit_en stays 2'b11 for the whole frame. frame_done still pulses every 32 cycles in both cases.
